// File: rtl/aes_pkg.sv
// Shared widths, FSM state type and 32-bit word helpers for the AES stream loader.
// Word 0 is the most significant word of a block: bits [127:96].
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = 4;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        UNLOAD
    } state_e;

    function automatic logic [AES_WORD_W-1:0] get_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [1:0]             idx
    );
        logic [AES_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] put_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [1:0]             idx,
        input logic [AES_WORD_W-1:0]  w
    );
        logic [AES_BLOCK_W-1:0] r;
        r = blk;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_word_loader.sv
// Valid/ready front/back end for the combinational AES-128 core: gathers key and
// plaintext words, lets the core settle for SETTLE_CYCLES, then streams the result out.
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_WORD_W-1:0]  in_data,
    input  logic                   in_is_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_WORD_W-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic [AES_BLOCK_W-1:0] core_msg,
    output logic [AES_BLOCK_W-1:0] core_key,
    input  logic [AES_BLOCK_W-1:0] core_result
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [1:0]             key_idx_q, key_idx_d;
    logic [2:0]             data_idx_q, data_idx_d;
    logic [1:0]             out_idx_q, out_idx_d;
    logic [7:0]             settle_cnt_q, settle_cnt_d;
    logic                   key_ok_q, key_ok_d;
    logic [AES_BLOCK_W-1:0] msg_q, msg_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [AES_BLOCK_W-1:0] result_q, result_d;
    logic                   in_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            key_idx_q    <= '0;
            data_idx_q   <= '0;
            out_idx_q    <= '0;
            settle_cnt_q <= '0;
            key_ok_q     <= 1'b0;
            msg_q        <= '0;
            key_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            key_idx_q    <= key_idx_d;
            data_idx_q   <= data_idx_d;
            out_idx_q    <= out_idx_d;
            settle_cnt_q <= settle_cnt_d;
            key_ok_q     <= key_ok_d;
            msg_q        <= msg_d;
            key_q        <= key_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_idx_d    = key_idx_q;
        data_idx_d   = data_idx_q;
        out_idx_d    = out_idx_q;
        settle_cnt_d = settle_cnt_q;
        key_ok_d     = key_ok_q;
        msg_d        = msg_q;
        key_d        = key_q;
        result_d     = result_q;
        in_ready     = 1'b0;
        in_accept    = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        out_data     = get_word(result_q, out_idx_q);

        case (state_q)
            LOAD: begin
                // A full plaintext buffer only blocks data words; key words keep flowing.
                in_ready  = rst_n && (in_is_key || (data_idx_q != 3'd4));
                in_accept = in_valid && in_ready;
                if (in_accept) begin
                    if (in_is_key) begin
                        key_d     = put_word(key_q, key_idx_q, in_data);
                        key_idx_d = key_idx_q + 2'd1;
                        if (key_idx_q == 2'd0) begin
                            key_ok_d = 1'b0;
                        end else if (key_idx_q == 2'd3) begin
                            key_ok_d = 1'b1;
                        end
                    end else begin
                        msg_d      = put_word(msg_q, data_idx_q[1:0], in_data);
                        data_idx_d = data_idx_q + 3'd1;
                    end
                end
                // Decide on the next-state values so WAIT starts right after the completing word.
                if ((data_idx_d == 3'd4) && key_ok_d) begin
                    state_d      = WAIT;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end

            WAIT: begin
                busy = 1'b1;
                if (settle_cnt_q == 8'd0) begin
                    result_d  = core_result;
                    out_idx_d = 2'd0;
                    state_d   = UNLOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end

            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (out_idx_q == 2'd3);
                if (out_ready) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d    = LOAD;
                        data_idx_d = 3'd0;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign core_msg = msg_q;
    assign core_key = key_q;

endmodule
